mul_operand_packer: RTL
=======================

Name: mul_operand_packer

Overview:
- Producer side of the 27x18 / sum-of-9x9 SIMD multiplier.
- Accepts a stream of operand beats on a valid/ready interface. In mode 0, each beat is one 27x18 pair. In mode 1, each beat is one 9x9 pair.
- Packs mode-1 beats into the 54-bit a/b lane layout the multiplier consumes, and presents one registered word per multiply with a/b, a_sign, b_sign and mode.
- Word leaves through a single-entry output register with valid/ready.

Parameters:
- LANES, 6, number of 9x9 lanes per packed word (fixed 6 for this multiplier, range 1..6)
- FLUSH_TIMEOUT, 16, idle cycles before a partial pack is auto-emitted (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_mode  in  1  0 = 27x18, 1 = sum of 9x9
- in_a  in  27  mode 0: full A; mode 1: A lane in bits [8:0], rest ignored
- in_b  in  18  mode 0: full B; mode 1: B lane in bits [8:0], rest ignored
- in_a_sign  in  1  A signed
- in_b_sign  in  1  B signed
- in_last  in  1  mode 1: close the pack after this beat
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts word
- a  out  54  packed A
- b  out  54  packed B
- a_sign  out  1  word A sign
- b_sign  out  1  word B sign
- mode  out  1  word mode
- out_lanes  out  3  valid lanes in word: 1 for mode 0, 1..6 for mode 1

Behaviour:
- Reset: out_valid=0, a=0, b=0, a_sign=0, b_sign=0, mode=0, out_lanes=0. Collection register cleared, lane_cnt=0, idle counter=0. Reset mid-pack discards the partial pack; nothing is emitted.
- Storage: a collection register holds acc_a, acc_b, acc_mode, acc_signs and lane_cnt (0..5), plus the output register. out_fire = out_valid && out_ready.
- slot_free = !out_valid || out_ready.
- Mismatch: lane_cnt>0 and the beat differs from the open pack in in_mode, in_a_sign or in_b_sign.
- in_ready = slot_free && !mismatch. in_ready may depend on input data; out_valid never depends on out_ready.
- Mode 0 beat accepted with lane_cnt=0 → next cycle:
  - a = {27'b0, in_a}, b = {36'b0, in_b}
  - out_valid=1, out_lanes=1
- Mode 0 beat with lane_cnt>0 is a mismatch.
- Mode 1 beat accepted → written to lane k = lane_cnt:
  - acc_a[9k+8:9k] = in_a[8:0], acc_b[9k+8:9k] = in_b[8:0]
  - Emit when k = LANES-1 or in_last=1: the output register loads acc with the new lane merged, all higher lanes zero, out_lanes=k+1, out_valid=1 next cycle; lane_cnt returns to 0.
  - Otherwise lane_cnt increments and nothing is emitted.
- Mismatch while slot_free: the partial pack is emitted (zero-padded, out_lanes=lane_cnt) and lane_cnt=0. The beat stays pending and is accepted on a later cycle as lane 0 of a new pack (or as a mode-0 word).
- Signs are per word. The first beat of a pack latches acc_signs.
- Output register holds its value while out_valid && !out_ready. It is never overwritten before out_fire.
- Emission and out_fire in the same cycle: new word loads and out_valid stays 1 (full throughput, 1 word per cycle in mode 0).
- Latency: accepted beat that closes a word → out_valid on the next clk edge.
- Zero padding is arithmetically neutral for the sum mode.

Optional Feature:
- Macro MUL_PACK_TIMEOUT_EN.
- Defined:
  - Idle counter increments each cycle that lane_cnt>0 and no beat is accepted, and resets on any accept.
  - At FLUSH_TIMEOUT and slot_free, the partial pack is emitted as for in_last, and the counter clears.
  - If the output is blocked, emission waits for slot_free.
- Undefined: no counter; a partial pack closes only via in_last, a mismatch or a full pack, and can stay open indefinitely.

Test Plan:
- Mode 0 signed beat in_a=27'h7FFFFFF, in_b=18'h00003, signs 1/1, out_ready=1 → next cycle: a=54'h0000007FFFFFF, b=54'h3, a_sign=1, b_sign=1, mode=0, out_lanes=1. Back-to-back beats sustain 1 word per cycle.
- Six mode 1 beats with A lanes 1..6 and B lanes 2..7, unsigned → one word: a lanes 0..5 = 1,2,3,4,5,6; b lanes 0..5 = 2..7; out_lanes=6, mode=1. The word appears exactly one cycle after beat 6.
- Three mode 1 beats, third with in_last=1 → out_lanes=3, lanes 3..5 of a and b are 0.
- Two mode 1 unsigned beats, then a beat with in_a_sign=1 → in_ready=0 for that cycle. Partial word is emitted with out_lanes=2 and signs 0/0. The signed beat is accepted the next cycle as lane 0 of a new pack with a_sign=1.
- Word held with out_ready=0 for 5 cycles while a full pack completes → a/b stay stable, in_ready=0. After out_ready=1, the held word is taken first, then the new word.
- Reset asserted with lane_cnt=4 → no word emitted, out_valid=0. With MUL_PACK_TIMEOUT_EN: a single mode 1 beat then 16 idle cycles → word with out_lanes=1.

Source files
------------

// File: rtl/mul_operand_packer.sv
// mul_operand_packer: packs 27x18 beats and 9x9 lane beats into registered 54-bit multiplier words (idle flush under MUL_PACK_TIMEOUT_EN)
module mul_operand_packer #(
  parameter int LANES = 6,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [26:0] in_a,
  input  logic [17:0] in_b,
  input  logic        in_a_sign,
  input  logic        in_b_sign,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [53:0] a,
  output logic [53:0] b,
  output logic        a_sign,
  output logic        b_sign,
  output logic        mode,
  output logic [2:0]  out_lanes
);
  logic [53:0] acc_a, acc_b, mrg_a, mrg_b;
  logic acc_mode, acc_a_sign, acc_b_sign;
  logic [2:0] lane_cnt;
  logic [5:0] sh;
  logic slot_free, mismatch, accept, close, flush, tmo;
  always_comb begin
    slot_free = !out_valid || out_ready;
    mismatch = lane_cnt != 3'd0 && (in_mode != acc_mode || in_a_sign != acc_a_sign || in_b_sign != acc_b_sign);
    in_ready = slot_free && !mismatch;
    accept = in_valid && in_ready;
    close = accept && in_mode && (lane_cnt == 3'(LANES - 1) || in_last);
    flush = slot_free && !accept && lane_cnt != 3'd0 && ((in_valid && mismatch) || tmo);
    sh = 6'(lane_cnt) * 6'd9;
    mrg_a = acc_a | ({45'd0, in_a[8:0]} << sh);
    mrg_b = acc_b | ({45'd0, in_b[8:0]} << sh);
  end
`ifdef MUL_PACK_TIMEOUT_EN
  localparam int IW = $clog2(FLUSH_TIMEOUT + 1);
  logic [IW-1:0] idle;
  assign tmo = idle == IW'(FLUSH_TIMEOUT);
  always_ff @(posedge clk) begin
    if (reset || accept || flush || lane_cnt == 3'd0) idle <= '0;
    else if (!tmo) idle <= idle + 1'b1;
  end
`else
  assign tmo = 1'b0 & |FLUSH_TIMEOUT;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a <= '0;
      b <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      mode <= 1'b0;
      out_lanes <= '0;
      acc_a <= '0;
      acc_b <= '0;
      acc_mode <= 1'b0;
      acc_a_sign <= 1'b0;
      acc_b_sign <= 1'b0;
      lane_cnt <= '0;
    end else begin
      if (accept && !in_mode) begin
        out_valid <= 1'b1;
        a <= {27'd0, in_a};
        b <= {36'd0, in_b};
        a_sign <= in_a_sign;
        b_sign <= in_b_sign;
        mode <= 1'b0;
        out_lanes <= 3'd1;
      end else if (close) begin
        out_valid <= 1'b1;
        a <= mrg_a;
        b <= mrg_b;
        a_sign <= in_a_sign;
        b_sign <= in_b_sign;
        mode <= 1'b1;
        out_lanes <= lane_cnt + 3'd1;
      end else if (flush) begin
        out_valid <= 1'b1;
        a <= acc_a;
        b <= acc_b;
        a_sign <= acc_a_sign;
        b_sign <= acc_b_sign;
        mode <= acc_mode;
        out_lanes <= lane_cnt;
      end else if (out_ready) out_valid <= 1'b0;
      if (close || flush) begin
        acc_a <= '0;
        acc_b <= '0;
        lane_cnt <= '0;
      end else if (accept && in_mode) begin
        acc_a <= mrg_a;
        acc_b <= mrg_b;
        acc_mode <= 1'b1;
        acc_a_sign <= in_a_sign;
        acc_b_sign <= in_b_sign;
        lane_cnt <= lane_cnt + 3'd1;
      end
    end
  end
endmodule
